// File: rtl/seq_shiftright_if.sv
// Request/response bundle for the iterative right shifter.
// The requester uses the master modport and the shifter uses the slave modport.
interface seq_shiftright_if #(
  parameter int N = 8
);
  logic         start;
  logic         arith;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport master (
    output start, arith, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, arith, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/seq_shiftright.sv
// Iterative right shifter, one bit position per clock, logical or arithmetic.
// This is a compact alternative to a barrel shifter when multi-cycle latency is acceptable.
module seq_shiftright #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_shiftright_if.slave  bus
);
  localparam int           CW   = $clog2(N + 1);
  localparam logic [N-1:0] NMAX = N'(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  work;
  logic [CW-1:0] count;
  logic          mode;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  result_q;
  logic [CW-1:0] start_count;

  // Any shift of N or more positions has the same effect as shifting by exactly N.
  assign start_count = (bus.b >= NMAX) ? CW'(N) : CW'(bus.b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      work     <= '0;
      count    <= '0;
      mode     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            work   <= bus.a;
            mode   <= bus.arith;
            count  <= start_count;
            state  <= SHIFT;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (count != '0) begin
            work  <= {mode & work[N-1], work[N-1:1]};
            count <= count - 1'b1;
          end else begin
            result_q <= work;
            done_q   <= 1'b1;
            state    <= DONE;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_seq_shiftright.sv
// Directed bench for seq_shiftright: hand-computed results, latency, busy/done timing,
// saturation, start-while-busy, back-to-back operations and asynchronous reset.
module tb_seq_shiftright;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic sawDone;

  seq_shiftright_if #(.N(8)) bus ();

  seq_shiftright #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called between clock edges; returns 1ns after the start edge with operands scrambled.
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB, input logic opArith);
    bus.a     = opA;
    bus.b     = opB;
    bus.arith = opArith;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~opA;
    bus.b     = 8'h01;
    bus.arith = ~opArith;
  endtask

  task automatic waitDone(input string tag, input logic [7:0] expRes, input int expBusy, input logic [7:0] prevRes);
    int busyCycles;
    busyCycles = 0;
    while (bus.busy === 1'b1 && busyCycles < 40) begin
      checkOutput({tag, "_held"}, {24'h0, bus.result}, {24'h0, prevRes});
      busyCycles++;
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_busycycles"}, busyCycles, expBusy);
    checkOutput({tag, "_done"}, {31'h0, bus.done}, 32'd1);
    checkOutput({tag, "_result"}, {24'h0, bus.result}, {24'h0, expRes});
  endtask

  task automatic finishOp(input string tag, input logic [7:0] expRes);
    @(posedge clk);
    #1;
    checkOutput({tag, "_donedrop"}, {31'h0, bus.done}, 32'd0);
    checkOutput({tag, "_idle"}, {31'h0, bus.busy}, 32'd0);
    checkOutput({tag, "_stable"}, {24'h0, bus.result}, {24'h0, expRes});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.arith   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;

    #3;
    checkOutput("reset_busy", {31'h0, bus.busy}, 32'd0);
    checkOutput("reset_done", {31'h0, bus.done}, 32'd0);
    checkOutput("reset_result", {24'h0, bus.result}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] logical and arithmetic shift by 2");
    @(negedge clk);
    applyStimulus(8'h96, 8'd2, 1'b0);
    waitDone("lsr2", 8'h25, 3, 8'h00);
    finishOp("lsr2", 8'h25);
    @(negedge clk);
    applyStimulus(8'h96, 8'd2, 1'b1);
    waitDone("asr2", 8'hE5, 3, 8'h25);
    finishOp("asr2", 8'hE5);

    $display("[TB] zero shift");
    @(negedge clk);
    applyStimulus(8'h96, 8'd0, 1'b0);
    waitDone("shift0", 8'h96, 1, 8'hE5);
    finishOp("shift0", 8'h96);

    $display("[TB] asynchronous reset mid-shift");
    @(negedge clk);
    applyStimulus(8'hFF, 8'd6, 1'b0);
    repeat (2) @(posedge clk);
    #4;
    checkOutput("prereset_busy", {31'h0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_busy", {31'h0, bus.busy}, 32'd0);
    checkOutput("async_done", {31'h0, bus.done}, 32'd0);
    checkOutput("async_result", {24'h0, bus.result}, 32'd0);
    #2;
    rst_n   = 1'b1;
    sawDone = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("postreset_nodone", {31'h0, sawDone}, 32'd0);
    checkOutput("postreset_busy", {31'h0, bus.busy}, 32'd0);
    checkOutput("postreset_result", {24'h0, bus.result}, 32'd0);

    $display("[TB] saturated shift amount");
    @(negedge clk);
    applyStimulus(8'h96, 8'd9, 1'b1);
    waitDone("asr9", 8'hFF, 9, 8'h00);
    finishOp("asr9", 8'hFF);
    @(negedge clk);
    applyStimulus(8'h96, 8'd9, 1'b0);
    waitDone("lsr9", 8'h00, 9, 8'hFF);
    finishOp("lsr9", 8'h00);

    $display("[TB] start while busy, then back-to-back start");
    @(negedge clk);
    applyStimulus(8'h80, 8'd3, 1'b1);
    @(negedge clk);
    bus.a     = 8'h01;
    bus.b     = 8'd1;
    bus.arith = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone("ignore", 8'hF0, 3, 8'h00);
    applyStimulus(8'h01, 8'd1, 1'b0);
    checkOutput("b2b_accept", {31'h0, bus.busy}, 32'd1);
    waitDone("b2b", 8'h00, 2, 8'hF0);
    finishOp("b2b", 8'h00);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
